chip8_timers: RTL and testbench

- Implements the CHIP-8 delay timer (DT) and sound timer (ST), both decremented at 60 Hz.
- Sits between the CPU and chip8_audio. The CPU loads DT/ST (FX15/FX18) and reads DT (FX07).
- active_out drives chip8_audio active_in directly: tone sounds while ST is non-zero.
- tick_out is also offered to the CPU/display as a 60 Hz frame strobe.

---
 rtl/chip8_pkg.sv | 12 +
 rtl/chip8_countdown.sv | 28 ++
 rtl/chip8_timers.sv | 67 ++++++
 tb/tb_chip8_timers.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants and timer type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chip8_pkg;

    localparam int CLK_HZ  = 98_304_000;
    localparam int TICK_HZ = 60;
    localparam int TIMER_W = 8;

    typedef logic [TIMER_W-1:0] timer_t;

endpackage

// File: rtl/chip8_countdown.sv
// Saturating down-counter with synchronous load; load beats decrement.
// Latency: load or decrement visible one cycle after the strobe.
// Backpressure: none, strobes are always accepted.
module chip8_countdown
    import chip8_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    input  logic             dec_in,
    output logic [WIDTH-1:0] val_out
);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            val_out <= '0;
        end else if (load_in) begin
            val_out <= load_val_in;
        end else if (dec_in && (val_out != '0)) begin
            // Stops at zero; never wraps back to all-ones.
            val_out <= val_out - WIDTH'(1);
        end
    end

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers driven by a 60 Hz tick divider.
// Latency: writes visible next cycle; tick decrement visible the cycle after tick_out.
// Backpressure: none; run_in=0 freezes the divider, writes still land.
module chip8_timers #(
    parameter int TICK_PERIOD = chip8_pkg::CLK_HZ / chip8_pkg::TICK_HZ,
    parameter int TIMER_W     = chip8_pkg::TIMER_W
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               run_in,
    input  logic               dt_we_in,
    input  logic               st_we_in,
    input  logic [TIMER_W-1:0] wdata_in,
    output logic [TIMER_W-1:0] dt_out,
    output logic [TIMER_W-1:0] st_out,
    output logic               tick_out,
    output logic               active_out
);

    localparam int                CNT_W    = $clog2(TICK_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Divider: tick_out is registered, so it is high the cycle after the wrap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt      <= '0;
            tick_out <= 1'b0;
        end else if (run_in) begin
            if (cnt == CNT_LAST) begin
                cnt      <= '0;
                tick_out <= 1'b1;
            end else begin
                cnt      <= cnt + CNT_W'(1);
                tick_out <= 1'b0;
            end
        end else begin
            tick_out <= 1'b0;
        end
    end

    chip8_countdown #(
        .WIDTH (TIMER_W)
    ) u_dt (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (dt_we_in),
        .load_val_in (wdata_in),
        .dec_in      (tick_out),
        .val_out     (dt_out)
    );

    chip8_countdown #(
        .WIDTH (TIMER_W)
    ) u_st (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (st_we_in),
        .load_val_in (wdata_in),
        .dec_in      (tick_out),
        .val_out     (st_out)
    );

    assign active_out = (st_out != '0);

endmodule

// File: tb/tb_chip8_timers.sv
// Scoreboard bench for chip8_timers with a 10-cycle tick period.
module tb_chip8_timers;

    localparam int TP = 10;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       run_in;
    logic       dt_we_in;
    logic       st_we_in;
    logic [7:0] wdata_in;
    logic [7:0] dt_out;
    logic [7:0] st_out;
    logic       tick_out;
    logic       active_out;

    chip8_timers #(
        .TICK_PERIOD (TP),
        .TIMER_W     (8)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .run_in     (run_in),
        .dt_we_in   (dt_we_in),
        .st_we_in   (st_we_in),
        .wdata_in   (wdata_in),
        .dt_out     (dt_out),
        .st_out     (st_out),
        .tick_out   (tick_out),
        .active_out (active_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string      tag;
        logic [7:0] dt;
        logic [7:0] st;
        logic       tick;
        logic       act;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
        end
    endtask

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic step(input string tag, input logic [7:0] e_dt, input logic [7:0] e_st,
                        input logic e_tick);
        exp_t e;
        e.tag  = tag;
        e.dt   = e_dt;
        e.st   = e_st;
        e.tick = e_tick;
        e.act  = (e_st != 8'd0);
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        edge_no++;
        e = sb.pop_front();
        check({e.tag, ".dt"},   32'(dt_out),     32'(e.dt));
        check({e.tag, ".st"},   32'(st_out),     32'(e.st));
        check({e.tag, ".tick"}, 32'(tick_out),   32'(e.tick));
        check({e.tag, ".act"},  32'(active_out), 32'(e.act));
    endtask

    initial begin
        int sv;
        rst_in   = 1'b1;
        run_in   = 1'b1;
        dt_we_in = 1'b0;
        st_we_in = 1'b0;
        wdata_in = 8'd0;

        // Reset state.
        step("rst", 8'd0, 8'd0, 1'b0);
        step("rst", 8'd0, 8'd0, 1'b0);
        rst_in   = 1'b0;
        edge_no  = 0;

        // First tick on counting edge 10, then every 10, one cycle wide.
        for (int e = 1; e <= 30; e++) step("tick", 8'd0, 8'd0, (e % TP) == 0);

        // Sound countdown 3 -> 0, saturating.
        st_we_in = 1'b1;
        wdata_in = 8'd3;
        step("st_ld", 8'd0, 8'd3, 1'b0);
        st_we_in = 1'b0;
        sv = 3;
        for (int e = 32; e <= 80; e++) begin
            step("st_cnt", 8'd0, 8'(sv), (e % TP) == 0);
            if ((e % TP) == 0 && sv != 0) sv--;
        end

        // Write lands in the same cycle tick_out is high: load wins.
        for (int e = 81; e <= 90; e++) step("pre_coll", 8'd0, 8'd0, (e % TP) == 0);
        dt_we_in = 1'b1;
        wdata_in = 8'd5;
        step("coll", 8'd5, 8'd0, 1'b0);
        dt_we_in = 1'b0;
        for (int e = 92; e <= 101; e++)
            step("post_coll", (e <= 100) ? 8'd5 : 8'd4, 8'd0, (e % TP) == 0);

        // Pause for 35 cycles with a write in the middle; cnt sits at 3.
        dt_we_in = 1'b1;
        wdata_in = 8'd7;
        step("p_ld", 8'd7, 8'd0, 1'b0);
        dt_we_in = 1'b0;
        step("p_run", 8'd7, 8'd0, 1'b0);
        run_in = 1'b0;
        for (int i = 0; i < 35; i++) begin
            dt_we_in = (i == 16);
            wdata_in = 8'd9;
            step("pause", (i >= 16) ? 8'd9 : 8'd7, 8'd0, 1'b0);
        end
        dt_we_in = 1'b0;
        run_in   = 1'b1;
        for (int i = 1; i <= 7; i++) step("resume", 8'd9, 8'd0, i == 7);
        step("res_dec", 8'd8, 8'd0, 1'b0);

        // Dual write, then cancel sound while DT keeps counting.
        dt_we_in = 1'b1;
        st_we_in = 1'b1;
        wdata_in = 8'h80;
        step("dual", 8'h80, 8'h80, 1'b0);
        dt_we_in = 1'b0;
        wdata_in = 8'h00;
        step("cancel", 8'h80, 8'h00, 1'b0);
        st_we_in = 1'b0;
        for (int e = 149; e <= 156; e++)
            step("dt_only", (e <= 155) ? 8'h80 : 8'h7f, 8'h00, e == 155);

        // Reset mid-count with a concurrent ST write: reset wins, phase restarts.
        dt_we_in = 1'b1;
        st_we_in = 1'b1;
        wdata_in = 8'd50;
        step("ld50", 8'd50, 8'd50, 1'b0);
        dt_we_in = 1'b0;
        st_we_in = 1'b0;
        for (int i = 0; i < 4; i++) step("to_cnt6", 8'd50, 8'd50, 1'b0);
        rst_in   = 1'b1;
        st_we_in = 1'b1;
        wdata_in = 8'd77;
        step("mid_rst", 8'd0, 8'd0, 1'b0);
        rst_in   = 1'b0;
        st_we_in = 1'b0;
        for (int i = 1; i <= 10; i++) step("post_rst", 8'd0, 8'd0, i == 10);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
